ringosc_meas_ctrl: RTL and testbench
====================================

# ringosc_meas_ctrl

Measurement sequencer for the on-chip ring oscillator. It enables the ring oscillator, waits a warm-up interval, then counts oscillator rising edges over a programmable gate window of system clocks. It reports the count with a done pulse and an overflow flag, and disables the oscillator between measurements to save power. It sits between the TT user I/O / register logic and the ring oscillator macro. The oscillator output reaches this block through an external divider so that `osc_in` runs below clk/4.

## Interface
- `CNT_W`, default 16: width of the edge counter and `count` result.
- `GATE_W`, default 16: width of the gate-length input.
- `WARMUP_CYC`, default 16: clocks between oscillator enable and the start of counting. Must be ≥ 3 to cover synchronizer fill.
- `clk` (in, 1): system clock. One clock domain.
- `rst` (in, 1): reset, synchronous and active-high.
- `start` (in, 1): begin a measurement. Sampled only in IDLE.
- `abort` (in, 1): cancel the current measurement.
- `gate_cycles` (in, GATE_W): gate length in clk cycles. Latched on accepted `start`.
- `osc_in` (in, 1): divided ring-oscillator output. Asynchronous to `clk`.
- `osc_en` (out, 1): enable to the ring oscillator NAND stage.
- `busy` (out, 1): high in any state other than IDLE.
- `done` (out, 1): one-cycle pulse when `count` is updated.
- `count` (out, CNT_W): last completed result. Held until the next completion.
- `overflow` (out, 1): the last completed measurement exceeded 2^CNT_W−1 edges.

## Operation
- **Synchronizer and edge detect**
  - `osc_in` passes through a 2-FF synchronizer (s1, s2), then a history register s3.
  - `rise = s2 & ~s3`.
  - All three registers run continuously and reset to 0.
- **States:** IDLE, WARMUP, MEASURE, DONE.
- **IDLE**
  - `osc_en`=0.
  - `start`=1 latches `gate_cycles` into `gate_q`, loads the warm-up timer with WARMUP_CYC−1, and moves to WARMUP.
- **WARMUP**
  - `osc_en`=1 and the timer decrements.
  - At timer 0: the running counter and overflow flag clear, and the gate timer loads from `gate_q`.
  - If `gate_q`=0, go to DONE (result 0). Otherwise go to MEASURE.
- **MEASURE**
  - `osc_en`=1.
  - Each cycle with `rise`=1 increments the running counter.
  - An increment at all-ones sets the internal overflow flag and wraps the counter to 0 (see Configuration).
  - The gate timer decrements. On the cycle it reads 1, that cycle's edge is still counted and the state moves to DONE.
- **DONE** (one cycle)
  - `count` ← running counter, `overflow` ← flag, `done`=1, `osc_en`=0.
  - Next state is IDLE.
- **Abort**
  - `abort`=1 in WARMUP or MEASURE returns the block to IDLE next cycle with `osc_en`=0.
  - No `done` pulse; `count` and `overflow` keep their previous values.
  - `abort` in IDLE or DONE is ignored; DONE always completes.
- **Simultaneous and edge cases**
  - `start` and `abort` both high in IDLE: `start` wins.
  - `start` while busy is ignored.
  - Changes to `gate_cycles` after acceptance have no effect.

## Timing
- **Reset values:** state=IDLE, `osc_en`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0, all timers, counters and sync flops 0.
- **Reset mid-operation:** returns to IDLE on the next edge, no `done` pulse.
- **Latency:** `start` sampled at edge T gives:
  - `osc_en`/`busy` high from T+1;
  - MEASURE from T+1+WARMUP_CYC;
  - `done` high in cycle T+1+WARMUP_CYC+gate_q;
  - IDLE (`busy`=0) in the following cycle.
- **Gate edges:** the gate covers exactly gate_q consecutive `rise` samples.
- **Edge-detect latency:** `rise` lags the `osc_in` edge by 2–3 clocks. Warm-up must absorb this.
- **Back-to-back runs:** earliest next accepted `start` is the cycle after `done`.

## Configuration
- `RINGOSC_CNT_SATURATE_EN`
  - Defined: the running counter holds at 2^CNT_W−1 on further edges, and `overflow` is still set.
  - Undefined: the counter wraps modulo 2^CNT_W, and `overflow` is set on the first wrap.

## Test plan
- Reset, then idle 20 clocks → `osc_en`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0.
- `osc_in` toggles every 4 clk (period 8), WARMUP_CYC=16, `gate_cycles`=64, `start` pulse at T → `osc_en`=1 at T+1, `done` at T+81, `count`=8, `overflow`=0, `busy`=0 at T+82.
- `gate_cycles`=0 → `done` at T+17 with `count`=0, `osc_en` low from T+17.
- CNT_W=4, `osc_in` period 8, gate 160 (20 edges):
  - with macro defined → `count`=15, `overflow`=1;
  - without it → `count`=4, `overflow`=1.
- Complete a run giving `count`=8, start a second run, assert `abort` mid-MEASURE → no `done`, `osc_en`=0 next cycle, `count` stays 8; `start` is accepted the cycle after.
- `start` pulsed during MEASURE with a different `gate_cycles` → ignored; the result and `done` timing match the original gate.

Source files
------------

// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enable, warm up, count edges over a gate window.
// Optional macro RINGOSC_CNT_SATURATE_EN makes the edge counter saturate instead of wrapping.
module ringosc_meas_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GATE_W     = 16,
    parameter int unsigned WARMUP_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              osc_in,
    output logic              osc_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int unsigned WarmW = (WARMUP_CYC > 2) ? $clog2(WARMUP_CYC) : 2;
    localparam logic [WarmW-1:0] WarmLoad = WarmW'(WARMUP_CYC - 1);

    typedef enum logic [1:0] {StIdle, StWarmup, StMeasure, StDone} state_e;

    state_e              state_q, state_d;
    logic                s1_q, s2_q, s3_q;
    logic [WarmW-1:0]    warm_q, warm_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [GATE_W-1:0]   gtmr_q, gtmr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                ovf_q, ovf_d, ovf_inc;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                rise;

    assign rise = s2_q & ~s3_q;

    // Running counter plus this cycle's edge; used both for the update and the final result.
    always_comb begin
        cnt_inc = cnt_q;
        ovf_inc = ovf_q;
        if (rise) begin
            if (&cnt_q) begin
                ovf_inc = 1'b1;
`ifdef RINGOSC_CNT_SATURATE_EN
                cnt_inc = cnt_q;
`else
                cnt_inc = '0;
`endif
            end else begin
                cnt_inc = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        gate_d     = gate_q;
        gtmr_d     = gtmr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gate_d  = gate_cycles;
                    warm_d  = WarmLoad;
                    state_d = StWarmup;
                end
            end
            StWarmup: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (warm_q == '0) begin
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    gtmr_d = gate_q;
                    if (gate_q == '0) begin
                        count_d    = '0;
                        overflow_d = 1'b0;
                        state_d    = StDone;
                    end else begin
                        state_d = StMeasure;
                    end
                end else begin
                    warm_d = warm_q - WarmW'(1);
                end
            end
            StMeasure: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    cnt_d  = cnt_inc;
                    ovf_d  = ovf_inc;
                    gtmr_d = gtmr_q - GATE_W'(1);
                    // Result is published on entry to DONE so it is valid alongside the pulse.
                    if (gtmr_q == GATE_W'(1)) begin
                        count_d    = cnt_inc;
                        overflow_d = ovf_inc;
                        state_d    = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            warm_q     <= '0;
            gate_q     <= '0;
            gtmr_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= osc_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            warm_q     <= warm_d;
            gate_q     <= gate_d;
            gtmr_q     <= gtmr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign osc_en   = (state_q == StWarmup) || (state_q == StMeasure);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Directed bench for ringosc_meas_ctrl: a default-width DUT and a CNT_W=4 DUT share all inputs.
module tb_ringosc_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] gate_cycles = '0;
    logic        osc_in = 1'b0;
    logic        osc_en, busy, done, overflow;
    logic [15:0] count;
    logic        osc_en4, busy4, done4, overflow4;
    logic [3:0]  count4;

    int checks = 0;
    int failures = 0;
    int n;

    ringosc_meas_ctrl #(.CNT_W(16), .GATE_W(16), .WARMUP_CYC(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_cycles(gate_cycles),
        .osc_in(osc_in), .osc_en(osc_en), .busy(busy), .done(done), .count(count),
        .overflow(overflow)
    );

    ringosc_meas_ctrl #(.CNT_W(4), .GATE_W(16), .WARMUP_CYC(16)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_cycles(gate_cycles),
        .osc_in(osc_in), .osc_en(osc_en4), .busy(busy4), .done(done4), .count(count4),
        .overflow(overflow4)
    );

    always #5 clk = ~clk;

    // Oscillator stand-in: toggles every 4 clocks, period 8, offset from the clock edge.
    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #2 osc_in = ~osc_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start for one sampled edge; n counts edges since (and including) that one.
    task automatic launch(input logic [15:0] gate);
        gate_cycles = gate;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        check_eq("rst_osc_en", osc_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_overflow", overflow, 0);

        // Basic run, gate 64 -> 8 edges.
        launch(16'd64);
        check_eq("run_osc_en_t1", osc_en, 1);
        check_eq("run_busy_t1", busy, 1);
        gate_cycles = 16'd5;
        wait_done();
        check_eq("run_done_latency", n, 81);
        check_eq("run_count", count, 8);
        check_eq("run_overflow", overflow, 0);
        check_eq("run_osc_en_done", osc_en, 0);
        tick();
        check_eq("run_busy_after", busy, 0);
        check_eq("run_done_after", done, 0);

        // Zero gate.
        launch(16'd0);
        wait_done();
        check_eq("zero_latency", n, 17);
        check_eq("zero_count", count, 0);
        check_eq("zero_osc_en", osc_en, 0);
        tick();

        // Gate 160 -> 20 edges; narrow counter overflows.
        launch(16'd160);
        wait_done();
        check_eq("ovf_latency", n, 177);
        check_eq("ovf_wide_count", count, 20);
        check_eq("ovf_wide_flag", overflow, 0);
`ifdef RINGOSC_CNT_SATURATE_EN
        check_eq("ovf_narrow_count", count4, 15);
`else
        check_eq("ovf_narrow_count", count4, 4);
`endif
        check_eq("ovf_narrow_flag", overflow4, 1);
        check_eq("ovf_narrow_done", done4, 1);
        tick();

        // Completed run (8), then abort mid-MEASURE.
        launch(16'd64);
        wait_done();
        check_eq("pre_abort_count", count, 8);
        tick();
        launch(16'd64);
        repeat (30) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_osc_en", osc_en, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_count", count, 8);
        launch(16'd64);
        check_eq("restart_busy", busy, 1);
        wait_done();
        check_eq("restart_latency", n, 81);
        check_eq("restart_count", count, 8);
        tick();

        // Start while busy with a different gate is ignored.
        launch(16'd64);
        while (done !== 1'b1 && n < 400) begin
            if (n == 40) begin
                gate_cycles = 16'd10;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check_eq("busy_start_latency", n, 81);
        check_eq("busy_start_count", count, 8);
        tick();

        // Reset mid-operation: idle next edge, result cleared, no done.
        launch(16'd64);
        repeat (25) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_osc_en", osc_en, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
